// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, registered carry, start/done handshake.
// Optional macro SERIAL_ADDER_SUB_EN adds a `sub` input for a-b with borrow on carry_out.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic [CW-1:0]    cnt;
  logic             carry, carry_next, bit_s;
  logic             accept, last;
  logic [WIDTH-1:0] b_load;
  logic             carry_init, final_co;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;

  // Subtraction is a + ~b + 1; the final carry is inverted to report borrow.
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
  assign final_co   = carry_next ^ sub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sub_q <= 1'b0;
    else if (accept) sub_q <= sub;
  end
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
  assign final_co   = carry_next;
`endif

  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign last       = (cnt == CW'(WIDTH - 1));
  assign bit_s      = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  assign res_next   = {bit_s, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (accept) begin
        a_sr   <= a;
        b_sr   <= b_load;
        res_sr <= '0;
        carry  <= carry_init;
        cnt    <= '0;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= res_next;
        carry  <= carry_next;
        cnt    <= cnt + CW'(1);
        // The final bit is shifted in on this same edge, so publish res_next.
        if (last) begin
          sum       <= res_next;
          carry_out <= final_co;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8) using immediate assertions.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy, done, carry_out;
  logic [W-1:0] sum;

  int passed = 0;
  int total  = 0;

  logic [W-1:0] prev_sum;
  logic         prev_co;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
  endtask

  // WIDTH RUN cycles: busy high, done low, previous result held.
  task automatic run_body();
    for (int i = 0; i < W; i++) begin
      check("busy_run", 32'(busy), 32'd1);
      check("done_run", 32'(done), 32'd0);
      check("sum_held", 32'(sum), 32'(prev_sum));
      check("co_held", 32'(carry_out), 32'(prev_co));
      tick();
    end
  endtask

  task automatic check_done(input string tag, input logic [W-1:0] es, input logic eco);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_co"}, 32'(carry_out), 32'(eco));
    prev_sum = es;
    prev_co  = eco;
  endtask

  task automatic idle_after(input string tag);
    tick();
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic full_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] es, input logic eco);
    start_op(av, bv);
    run_body();
    check_done(tag, es, eco);
    idle_after(tag);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif
    prev_sum = '0;
    prev_co  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_co", 32'(carry_out), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    full_op("add25_13", 8'h25, 8'h13, 8'h38, 1'b0);
    full_op("addFF_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    full_op("add80_80", 8'h80, 8'h80, 8'h00, 1'b1);
    full_op("add00_00", 8'h00, 8'h00, 8'h00, 1'b0);

    // Back-to-back: start held in the DONE cycle of the previous operation.
    start_op(8'h25, 8'h13);
    run_body();
    check_done("b2b_first", 8'h38, 1'b0);
    start_op(8'h0F, 8'hF0);
    check("b2b_no_bubble", 32'(busy), 32'd1);
    run_body();
    check_done("b2b_second", 8'hFF, 1'b0);
    idle_after("b2b");

    // Start pulse mid-RUN is ignored; operand changes after acceptance are ignored.
    start_op(8'h10, 8'h20);
    for (int i = 0; i < W; i++) begin
      check("ign_busy", 32'(busy), 32'd1);
      check("ign_sum_held", 32'(sum), 32'(prev_sum));
      start = (i == 3);
      a     = (i == 3) ? 8'h01 : 8'(8'hA5 + i);
      b     = (i == 3) ? 8'h01 : 8'(8'h3C ^ i);
      tick();
    end
    start = 1'b0;
    check_done("ignore", 8'h30, 1'b0);
    idle_after("ignore");

    // Reset while processing bit 4 aborts the operation.
    start_op(8'h55, 8'h66);
    for (int i = 0; i < 4; i++) tick();
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_co", 32'(carry_out), 32'd0);
    tick();
    rst_n = 1'b1;
    prev_sum = '0;
    prev_co  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("quiet_done", 32'(done), 32'd0);
      check("quiet_busy", 32'(busy), 32'd0);
      check("quiet_sum", 32'(sum), 32'd0);
    end
    full_op("add7F_01", 8'h7F, 8'h01, 8'h80, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    full_op("sub05_07", 8'h05, 8'h07, 8'hFE, 1'b1);
    full_op("sub07_05", 8'h07, 8'h05, 8'h02, 1'b0);
    sub = 1'b0;
    full_op("sub0_05_07", 8'h05, 8'h07, 8'h0C, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder: it accepts two parallel operands and produces the sum LSB-first over WIDTH clocks, using one full-adder cell and a registered carry.
- It is the additive counterpart of the team's half subtractor, reusing the XOR/AND half-cell arithmetic in sequential form.
- Intended for area-constrained datapaths where multi-cycle add latency is acceptable.
- Start/done handshake toward a controlling FSM.

Parameters:
- WIDTH, 8, operand/sum width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an operation; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge only.
- b  input  WIDTH  operand B; captured on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum/carry_out are valid and updated.
- sum  output  WIDTH  result; held stable from done until the next accepted start completes.
- carry_out  output  1  final carry out of the MSB; held like sum.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - busy=0, done=0, sum=0, carry_out=0.
  - Carry register=0, bit counter=0, shift registers=0.
  - Release is synchronous to clk; no operation is in progress after reset.
- States: IDLE, RUN, DONE.
  - IDLE: on an edge with start=1, load A/B shift regs from a/b, clear the carry register and the counter, and go to RUN. Otherwise stay.
  - RUN: each edge computes s = A[0]^B[0]^c and c_next = (A[0]&B[0]) | (c&(A[0]^B[0])). Shift A and B right by one. Shift s into the MSB of the result shift reg. Counter increments.
  - RUN exit: on the edge processing bit WIDTH-1 (counter == WIDTH-1), copy the result reg to sum and c_next to carry_out, then go to DONE.
  - DONE: done=1 for exactly this one cycle.
    - Next edge with start=1: accept new operands, go to RUN (back-to-back, no IDLE bubble).
    - Otherwise: go to IDLE.
- Latency: start accepted at edge k; done is high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- Registered outputs:
  - busy is high exactly in RUN cycles (WIDTH cycles per operation).
  - done and busy are never high together.
- start while in RUN is ignored: no restart, and operands are not re-sampled.
- a/b may change freely after the accepting edge; the result depends only on the captured values.
- sum/carry_out change only on the edge entering DONE; intermediate bits are never visible on sum.
- Arithmetic is modulo 2^WIDTH; carry_out is bit WIDTH of a+b.
- Reset asserted mid-RUN: the operation is aborted immediately and all outputs return to reset values. No done is generated for the aborted operation.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit, listed after b), captured with the operands.
  - When captured sub=1, the B shift reg loads ~b and the carry register initialises to 1, so sum = a-b mod 2^WIDTH.
  - carry_out then reports borrow = ~final carry, i.e. 1 when a<b unsigned.
  - When captured sub=0, behaviour is identical to the macro-undefined build.
- Undefined: no sub port; add-only.

Test Plan:
- WIDTH=8, reset, start with a=0x25, b=0x13 -> busy high for 8 cycles, then done pulse with sum=0x38, carry_out=0.
- a=0xFF, b=0x01 -> sum=0x00, carry_out=1. Then a=0x80, b=0x80 -> sum=0x00, carry_out=1. Then a=0x00, b=0x00 -> sum=0x00, carry_out=0.
- Hold start=1 in the DONE cycle with a=0x0F, b=0xF0 -> next operation starts immediately, with no IDLE cycle. Second done after 9 cycles with sum=0xFF, carry_out=0; previous sum held until then.
- Pulse start with new operands (a=0x01, b=0x01) mid-RUN of 0x10+0x20 -> ignored; result sum=0x30. Also change a/b after acceptance -> result unaffected.
- Assert rst_n=0 at RUN bit 4, release, wait 20 cycles -> outputs all 0, no done pulse, busy=0. Then a fresh 0x7F+0x01 -> sum=0x80, carry_out=0.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=0x05, b=0x07 -> sum=0xFE, carry_out(borrow)=1.
  - sub=1, a=0x07, b=0x05 -> sum=0x02, borrow=0.
  - sub=0, a=0x05, b=0x07 -> sum=0x0C, carry_out=0.
